// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port memory bus arbiter: request kinds, arbiter
// states and port indices.
package mem_bus_arbiter_pkg;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_req_slot.sv
// One request slot: latches a pulsed request, flags duplicates while busy and
// counts the cycles the latched request waits before being granted.
module mem_req_slot
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             type_i,
  input  logic [15:0]      addr_i,
  input  logic [15:0]      data_i,
  input  logic             grant_i,
  input  logic             done_i,
  output logic             pending_o,
  output logic             type_o,
  output logic [15:0]      addr_o,
  output logic [15:0]      data_o,
  output logic             dup_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             busy_q, busy_d;
  logic             inflight_q, inflight_d;
  logic             type_q, type_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d     = busy_q;
    inflight_d = inflight_q;
    type_d     = type_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    pending_o  = busy_q && !inflight_q;
    // Busy covers the completion cycle too, so a request there is a duplicate.
    dup_o      = req_i && busy_q;

    if (req_i && !busy_q) begin
      busy_d = 1'b1;
      type_d = type_i;
      addr_d = addr_i;
      data_d = data_i;
    end
    if (grant_i) begin
      inflight_d = 1'b1;
    end
    if (done_i) begin
      busy_d     = 1'b0;
      inflight_d = 1'b0;
    end

    if (grant_i) begin
      cnt_d = '0;
    end else if (pending_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      inflight_q <= 1'b0;
      type_q     <= REQ_READ;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign type_o = type_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port 16-bit memory bus between the core
// (port 0) and a secondary master (port 1), one transaction at a time.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_request,
  input  logic        r0_request_type,
  input  logic [15:0] r0_request_address,
  input  logic [15:0] r0_data_out,
  output logic [15:0] r0_memory_in,
  output logic        r0_memory_ready,
  output logic        r0_write_complete,
  input  logic        r1_request,
  input  logic        r1_request_type,
  input  logic [15:0] r1_request_address,
  input  logic [15:0] r1_data_out,
  output logic [15:0] r1_memory_in,
  output logic        r1_memory_ready,
  output logic        r1_write_complete,
  output logic        mem_request,
  output logic        mem_request_type,
  output logic [15:0] mem_request_address,
  output logic [15:0] mem_data_out,
  input  logic [15:0] mem_memory_in,
  input  logic        mem_memory_ready,
  input  logic        mem_write_complete,
  output logic        memory_critical,
  output logic        protocol_error
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  logic [1:0]       pend, s_type, grant, done, dup;
  logic [15:0]      s_addr [2];
  logic [15:0]      s_data [2];
  logic [CNT_W-1:0] s_cnt  [2];

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        mreq_q, mreq_d;
  logic        mtype_q, mtype_d;
  logic [15:0] maddr_q, maddr_d;
  logic [15:0] mdata_q, mdata_d;
  logic [15:0] in0_q, in0_d, in1_q, in1_d;
  logic [1:0]  rdy_q, rdy_d, wc_q, wc_d;
  logic        err_q, err_d;
  logic        crit_q, crit_d;
  logic        pick, finish;

  mem_req_slot #(.CNT_W(CNT_W)) u_slot_cpu (
    .clk      (clk),
    .rst      (reset),
    .req_i    (r0_request),
    .type_i   (r0_request_type),
    .addr_i   (r0_request_address),
    .data_i   (r0_data_out),
    .grant_i  (grant[PORT_CPU]),
    .done_i   (done[PORT_CPU]),
    .pending_o(pend[PORT_CPU]),
    .type_o   (s_type[PORT_CPU]),
    .addr_o   (s_addr[PORT_CPU]),
    .data_o   (s_data[PORT_CPU]),
    .dup_o    (dup[PORT_CPU]),
    .cnt_o    (s_cnt[PORT_CPU])
  );

  mem_req_slot #(.CNT_W(CNT_W)) u_slot_aux (
    .clk      (clk),
    .rst      (reset),
    .req_i    (r1_request),
    .type_i   (r1_request_type),
    .addr_i   (r1_request_address),
    .data_i   (r1_data_out),
    .grant_i  (grant[PORT_AUX]),
    .done_i   (done[PORT_AUX]),
    .pending_o(pend[PORT_AUX]),
    .type_o   (s_type[PORT_AUX]),
    .addr_o   (s_addr[PORT_AUX]),
    .data_o   (s_data[PORT_AUX]),
    .dup_o    (dup[PORT_AUX]),
    .cnt_o    (s_cnt[PORT_AUX])
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    mreq_d  = 1'b0;
    mtype_d = mtype_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    rdy_d   = 2'b00;
    wc_d    = 2'b00;
    err_d   = err_q | (|dup);
    crit_d  = (s_cnt[PORT_CPU] >= Limit) || (s_cnt[PORT_AUX] >= Limit);
    grant   = 2'b00;
    done    = 2'b00;
    pick    = 1'b0;
    finish  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_memory_ready || mem_write_complete) begin
          err_d = 1'b1;
        end
        if (|pend) begin
          // On a tie the port that did not win last time goes first.
          pick        = (&pend) ? ~last_q : pend[PORT_AUX];
          grant[pick] = 1'b1;
          owner_d     = pick;
          last_d      = pick;
          mreq_d      = 1'b1;
          mtype_d     = s_type[pick];
          maddr_d     = s_addr[pick];
          mdata_d     = s_data[pick];
          state_d     = StWait;
        end
      end
      StWait: begin
        if (mtype_q == REQ_READ) begin
          if (mem_write_complete) begin
            err_d = 1'b1;
          end
          if (mem_memory_ready) begin
            finish         = 1'b1;
            rdy_d[owner_q] = 1'b1;
            if (owner_q == PORT_AUX) begin
              in1_d = mem_memory_in;
            end else begin
              in0_d = mem_memory_in;
            end
          end
        end else begin
          if (mem_memory_ready) begin
            err_d = 1'b1;
          end
          if (mem_write_complete) begin
            finish        = 1'b1;
            wc_d[owner_q] = 1'b1;
          end
        end
        if (finish) begin
          done[owner_q] = 1'b1;
          state_d       = StIdle;
          mtype_d       = REQ_READ;
          maddr_d       = '0;
          mdata_d       = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= PORT_CPU;
      last_q  <= PORT_AUX;
      mreq_q  <= 1'b0;
      mtype_q <= REQ_READ;
      maddr_q <= '0;
      mdata_q <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
      rdy_q   <= 2'b00;
      wc_q    <= 2'b00;
      err_q   <= 1'b0;
      crit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      mreq_q  <= mreq_d;
      mtype_q <= mtype_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      rdy_q   <= rdy_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
      crit_q  <= crit_d;
    end
  end

  assign r0_memory_in        = in0_q;
  assign r0_memory_ready     = rdy_q[PORT_CPU];
  assign r0_write_complete   = wc_q[PORT_CPU];
  assign r1_memory_in        = in1_q;
  assign r1_memory_ready     = rdy_q[PORT_AUX];
  assign r1_write_complete   = wc_q[PORT_AUX];
  assign mem_request         = mreq_q;
  assign mem_request_type    = mtype_q;
  assign mem_request_address = maddr_q;
  assign mem_data_out        = mdata_q;
  assign memory_critical     = crit_q;
  assign protocol_error      = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter: port 0 uses addresses with bit 15
// clear, port 1 with bit 15 set, so each memory transaction identifies its owner.
module tb_mem_bus_arbiter;

  localparam int Limit = 4;
  localparam int None  = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_request = 1'b0, r0_request_type = 1'b0;
  logic [15:0] r0_request_address = '0, r0_data_out = '0;
  logic [15:0] r0_memory_in;
  logic        r0_memory_ready, r0_write_complete;
  logic        r1_request = 1'b0, r1_request_type = 1'b0;
  logic [15:0] r1_request_address = '0, r1_data_out = '0;
  logic [15:0] r1_memory_in;
  logic        r1_memory_ready, r1_write_complete;
  logic        mem_request, mem_request_type;
  logic [15:0] mem_request_address, mem_data_out;
  logic [15:0] mem_memory_in = '0;
  logic        mem_memory_ready = 1'b0, mem_write_complete = 1'b0;
  logic        memory_critical, protocol_error;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(Limit), .CNT_W(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .r0_request         (r0_request),
    .r0_request_type    (r0_request_type),
    .r0_request_address (r0_request_address),
    .r0_data_out        (r0_data_out),
    .r0_memory_in       (r0_memory_in),
    .r0_memory_ready    (r0_memory_ready),
    .r0_write_complete  (r0_write_complete),
    .r1_request         (r1_request),
    .r1_request_type    (r1_request_type),
    .r1_request_address (r1_request_address),
    .r1_data_out        (r1_data_out),
    .r1_memory_in       (r1_memory_in),
    .r1_memory_ready    (r1_memory_ready),
    .r1_write_complete  (r1_write_complete),
    .mem_request        (mem_request),
    .mem_request_type   (mem_request_type),
    .mem_request_address(mem_request_address),
    .mem_data_out       (mem_data_out),
    .mem_memory_in      (mem_memory_in),
    .mem_memory_ready   (mem_memory_ready),
    .mem_write_complete (mem_write_complete),
    .memory_critical    (memory_critical),
    .protocol_error     (protocol_error)
  );

  typedef struct packed {
    logic        typ;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q [2][$];
  logic        rec_typ [2];
  logic [15:0] rec_addr [2];
  logic [15:0] rec_data [2];
  int          samp_e [2];
  int          gnt_e [2];
  bit          rec_v [2];
  int          pulse_cnt [2];
  bit          last_g;
  bit          bus_busy;
  bit          resp_en;
  int          cyc;
  int          n_chk;
  int          n_pass;
  logic [15:0] tb_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [95:0] all_outputs();
    return 96'({r0_memory_in, r0_memory_ready, r0_write_complete, r1_memory_in,
                r1_memory_ready, r1_write_complete, mem_request, mem_request_type,
                mem_request_address, mem_data_out, memory_critical, protocol_error});
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      rec_v[i] = 1'b0;
      gnt_e[i] = None;
    end
    last_g   = 1'b1;
    bus_busy = 1'b0;
  endtask

  task automatic drive(input bit p, input logic rq, input logic t, input logic [15:0] a,
                       input logic [15:0] d);
    if (!p) begin
      r0_request = rq; r0_request_type = t; r0_request_address = a; r0_data_out = d;
    end else begin
      r1_request = rq; r1_request_type = t; r1_request_address = a; r1_data_out = d;
    end
  endtask

  // Reference: reads return the last value this port wrote, else the default pattern.
  task automatic issue(input bit p, input logic t, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.typ = t;
    if (t == 1'b0) begin
      e.data = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    end else begin
      e.data = d;
      ref_mem[a] = d;
    end
    exp_q[p].push_back(e);
    rec_typ[p] = t; rec_addr[p] = a; rec_data[p] = d;
    samp_e[p] = cyc + 1; gnt_e[p] = None; rec_v[p] = 1'b1;
    drive(p, 1'b1, t, a, d);
    tick();
    drive(p, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic wait_idle(input bit p);
    int n = 0;
    while (exp_q[p].size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check($sformatf("drain_port%0d", p), 96'(exp_q[p].size()), 96'(0));
  endtask

  task automatic port_driver(input bit p, input int count);
    for (int i = 0; i < count; i++) begin
      wait_idle(p);
      repeat ($urandom_range(0, 4)) tick();
      issue(p, 1'($urandom), {p, 11'd0, 4'($urandom_range(0, 15))}, 16'($urandom));
    end
  endtask

  task automatic cyc_count();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic responder();
    logic        t;
    logic [15:0] a, d;
    forever begin
      @(negedge clk);
      if (!reset && resp_en && mem_request) begin
        t = mem_request_type; a = mem_request_address; d = mem_data_out;
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #1;
        if (t == 1'b0) begin
          mem_memory_in = tb_mem.exists(a) ? tb_mem[a] : dflt(a);
          mem_memory_ready = 1'b1;
        end else begin
          tb_mem[a] = d;
          mem_write_complete = 1'b1;
        end
        tick();
        mem_memory_ready = 1'b0;
        mem_write_complete = 1'b0;
        mem_memory_in = 16'($urandom);
      end
    end
  endtask

  task automatic monitor();
    bit          p, q, exp_c;
    logic        rdy, wc;
    logic [15:0] din;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_request) begin
          p = mem_request_address[15];
          q = !p;
          check("grant_bus_free", 96'(bus_busy), 96'(0));
          check("grant_eligible", 96'(rec_v[p] && samp_e[p] < cyc && gnt_e[p] == None), 96'(1));
          check("grant_fields", 96'({mem_request_type, mem_request_address, mem_data_out}),
                96'({rec_typ[p], rec_addr[p], rec_data[p]}));
          if (rec_v[q] && samp_e[q] < cyc && gnt_e[q] == None)
            check("round_robin_tie", 96'(p), 96'(!last_g));
          gnt_e[p] = cyc; last_g = p; bus_busy = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
          p   = i[0];
          rdy = p ? r1_memory_ready : r0_memory_ready;
          wc  = p ? r1_write_complete : r0_write_complete;
          din = p ? r1_memory_in : r0_memory_in;
          if (rdy || wc) begin
            pulse_cnt[p]++;
            if (exp_q[p].size() == 0) begin
              check($sformatf("unexpected_pulse_port%0d", p), 96'({rdy, wc}), 96'(0));
            end else begin
              e = exp_q[p].pop_front();
              check($sformatf("pulse_kind_port%0d", p), 96'({rdy, wc}),
                    96'(e.typ ? 2'b01 : 2'b10));
              if (!e.typ) check($sformatf("read_data_port%0d", p), 96'(din), 96'(e.data));
              bus_busy = 1'b0;
            end
          end
        end
        // Critical after edge k reflects a request ungranted at k-1 after Limit waits.
        exp_c = 1'b0;
        for (int i = 0; i < 2; i++) begin
          if (rec_v[i] && samp_e[i] + Limit <= cyc - 1 && cyc - 1 < gnt_e[i]) exp_c = 1'b1;
        end
        check("memory_critical", 96'(memory_critical), 96'(exp_c));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int pc0;
    clear_model();
    resp_en = 1'b1;
    fork
      cyc_count();
      responder();
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
      end
    join_none

    do_reset();
    check("reset_outputs", all_outputs(), 96'(0));

    // Simultaneous requests right after reset: port 0 must go first.
    fork
      issue(1'b0, 1'b0, 16'h0040, 16'h0000);
      issue(1'b1, 1'b1, 16'h8000, 16'h1234);
    join
    wait_idle(1'b0);
    wait_idle(1'b1);

    fork
      port_driver(1'b0, 30);
      port_driver(1'b1, 30);
    join
    wait_idle(1'b0);
    wait_idle(1'b1);
    check("no_error_clean_traffic", 96'(protocol_error), 96'(0));

    // Back-to-back duplicate on port 0, then a spurious ready in idle.
    do_reset();
    check("error_clear_after_reset", 96'(protocol_error), 96'(0));
    issue(1'b0, 1'b0, 16'h0040, 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 16'h0123, 16'hFFFF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    wait_idle(1'b0);
    check("error_after_duplicate", 96'(protocol_error), 96'(1));
    tick();
    mem_memory_ready = 1'b1;
    tick();
    mem_memory_ready = 1'b0;
    tick();
    check("error_sticky", 96'(protocol_error), 96'(1));

    // Reset while a port 0 read is in flight, then a late memory response.
    do_reset();
    resp_en = 1'b0;
    issue(1'b0, 1'b0, 16'h0040, 16'h0000);
    for (int n = 0; n < 20 && gnt_e[0] == None; n++) tick();
    check("midwait_granted", 96'(gnt_e[0] != None), 96'(1));
    tick();
    reset = 1'b1;
    clear_model();
    tick();
    reset = 1'b0;
    tick();
    check("midwait_reset_outputs", all_outputs(), 96'(0));
    pc0 = pulse_cnt[0];
    mem_memory_in = 16'hBEEF;
    mem_memory_ready = 1'b1;
    tick();
    mem_memory_ready = 1'b0;
    tick();
    tick();
    check("late_response_error", 96'(protocol_error), 96'(1));
    check("late_response_no_pulse", 96'(pulse_cnt[0]), 96'(pc0));
    check("late_response_no_data", 96'(r0_memory_in), 96'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
